uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// UART transmitter with a small transmit FIFO. Baud divisor, parity mode and
// stop-bit count are captured when each frame starts, so configuration changes
// only take effect on the next frame.
module uart_tx_cfg #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 16
) (
   input  logic                        uart_clock,
   input  logic                        uart_reset,
   input  logic                        tx_valid,
   input  logic [DATA_W-1:0]           tx_data,
   output logic                        tx_ready,
   input  logic [DIV_W-1:0]            baud_div,
   input  logic [1:0]                  parity_mode,
   input  logic                        stop_bits,
   input  logic                        tx_enable,
   output logic                        uart_d_out,
   output logic                        tx_busy,
   output logic                        tx_done,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int IDX_W = $clog2(DATA_W);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} stateT;

   stateT             stateQ, stateD;
   logic [DATA_W-1:0] fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wrPtrQ, wrPtrD, rdPtrQ, rdPtrD;
   logic [LVL_W-1:0]  levelQ, levelD;
   logic [DATA_W-1:0] shiftQ, shiftD;
   logic [DIV_W-1:0]  divCntQ, divCntD, effDivQ, effDivD;
   logic [IDX_W-1:0]  bitIdxQ, bitIdxD;
   logic              parOnQ, parOnD, parBitQ, parBitD;
   logic              stopTwoQ, stopTwoD;
   logic              lineQ, lineD, doneQ, doneD;
   logic              push, pop, fifoEmpty, frameGo, bitEnd, loadFrame;

   // Flow control works from registered occupancy only, so a full FIFO never
   // accepts a word even if a pop happens in the same cycle.
   assign tx_ready   = (levelQ != LVL_W'(FIFO_DEPTH));
   assign fifoEmpty  = (levelQ == '0);
   assign push       = tx_valid && tx_ready;
   assign frameGo    = !fifoEmpty && tx_enable;
   assign pop        = loadFrame;
   assign fifo_level = levelQ;
   assign uart_d_out = lineQ;
   assign tx_busy    = (stateQ != IDLE);
   assign tx_done    = doneQ;

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge uart_clock) begin
      if (push) begin
         fifoMem[wrPtrQ] <= tx_data;
      end
   end

   // FIFO pointer and occupancy bookkeeping.
   always_comb begin
      wrPtrD = wrPtrQ;
      rdPtrD = rdPtrQ;
      levelD = levelQ;
      if (push) begin
         wrPtrD = wrPtrQ + PTR_W'(1);
      end
      if (pop) begin
         rdPtrD = rdPtrQ + PTR_W'(1);
      end
      if (push && !pop) begin
         levelD = levelQ + LVL_W'(1);
      end else if (pop && !push) begin
         levelD = levelQ - LVL_W'(1);
      end
   end

   // Frame sequencing: every state lasts whole bit periods; a new frame is
   // loaded from IDLE or straight out of the last stop bit.
   always_comb begin
      stateD    = stateQ;
      divCntD   = divCntQ;
      bitIdxD   = bitIdxQ;
      shiftD    = shiftQ;
      effDivD   = effDivQ;
      parOnD    = parOnQ;
      parBitD   = parBitQ;
      stopTwoD  = stopTwoQ;
      doneD     = 1'b0;
      loadFrame = 1'b0;
      bitEnd    = (divCntQ == effDivQ);
      if (stateQ != IDLE) begin
         divCntD = bitEnd ? '0 : divCntQ + DIV_W'(1);
      end
      unique case (stateQ)
         IDLE: begin
            if (frameGo) begin
               loadFrame = 1'b1;
            end
         end
         START: begin
            if (bitEnd) begin
               stateD  = DATA;
               bitIdxD = '0;
            end
         end
         DATA: begin
            if (bitEnd) begin
               if (bitIdxQ == IDX_W'(DATA_W - 1)) begin
                  bitIdxD = '0;
                  stateD  = parOnQ ? PARITY : STOP;
               end else begin
                  bitIdxD = bitIdxQ + IDX_W'(1);
                  shiftD  = shiftQ >> 1;
               end
            end
         end
         PARITY: begin
            if (bitEnd) begin
               stateD  = STOP;
               bitIdxD = '0;
            end
         end
         STOP: begin
            if (bitEnd) begin
               if (bitIdxQ == IDX_W'(stopTwoQ)) begin
                  doneD = 1'b1;
                  if (frameGo) begin
                     loadFrame = 1'b1;
                  end else begin
                     stateD = IDLE;
                  end
               end else begin
                  bitIdxD = bitIdxQ + IDX_W'(1);
               end
            end
         end
         default: stateD = IDLE;
      endcase
      if (loadFrame) begin
         stateD   = START;
         divCntD  = '0;
         bitIdxD  = '0;
         shiftD   = fifoMem[rdPtrQ];
         effDivD  = (baud_div == '0) ? DIV_W'(1) : baud_div;
         parOnD   = parity_mode[0] ^ parity_mode[1];
         parBitD  = (^fifoMem[rdPtrQ]) ^ (parity_mode == 2'b10);
         stopTwoD = stop_bits;
      end
   end

   // The line level is derived from the state being entered so the output
   // register lines up with the state register.
   always_comb begin
      lineD = 1'b1;
      unique case (stateD)
         IDLE:    lineD = 1'b1;
         START:   lineD = 1'b0;
         DATA:    lineD = shiftD[0];
         PARITY:  lineD = parBitQ;
         STOP:    lineD = 1'b1;
         default: lineD = 1'b1;
      endcase
   end

   // All state registers, cleared asynchronously by the active-low reset.
   always_ff @(posedge uart_clock or negedge uart_reset) begin
      if (!uart_reset) begin
         stateQ   <= IDLE;
         wrPtrQ   <= '0;
         rdPtrQ   <= '0;
         levelQ   <= '0;
         shiftQ   <= '0;
         divCntQ  <= '0;
         effDivQ  <= DIV_W'(1);
         bitIdxQ  <= '0;
         parOnQ   <= 1'b0;
         parBitQ  <= 1'b0;
         stopTwoQ <= 1'b0;
         lineQ    <= 1'b1;
         doneQ    <= 1'b0;
      end else begin
         stateQ   <= stateD;
         wrPtrQ   <= wrPtrD;
         rdPtrQ   <= rdPtrD;
         levelQ   <= levelD;
         shiftQ   <= shiftD;
         divCntQ  <= divCntD;
         effDivQ  <= effDivD;
         bitIdxQ  <= bitIdxD;
         parOnQ   <= parOnD;
         parBitQ  <= parBitD;
         stopTwoQ <= stopTwoD;
         lineQ    <= lineD;
         doneQ    <= doneD;
      end
   end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: directed frames with hand-computed expectations
// plus a randomized run, all cross-checked against a frame-level model.
module tb_uart_tx_cfg;
   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int DIV_W      = 16;

   logic              uart_clock  = 1'b0;
   logic              uart_reset  = 1'b0;
   logic              tx_valid    = 1'b0;
   logic [DATA_W-1:0] tx_data     = '0;
   logic              tx_ready;
   logic [DIV_W-1:0]  baud_div    = 16'd9;
   logic [1:0]        parity_mode = 2'b00;
   logic              stop_bits   = 1'b0;
   logic              tx_enable   = 1'b0;
   logic              uart_d_out;
   logic              tx_busy;
   logic              tx_done;
   logic [2:0]        fifo_level;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   // Frame-level model state: queued words and the bit list of the frame in flight.
   logic [DATA_W-1:0] mQ[$];
   int                mBits[12];
   int                mNbits  = 0;
   int                mBitLen = 1;
   int                mCycle  = 0;
   bit                mBusy   = 1'b0;
   bit                mDone   = 1'b0;

   uart_tx_cfg #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
      .uart_clock (uart_clock),
      .uart_reset (uart_reset),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .baud_div   (baud_div),
      .parity_mode(parity_mode),
      .stop_bits  (stop_bits),
      .tx_enable  (tx_enable),
      .uart_d_out (uart_d_out),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .fifo_level (fifo_level)
   );

   // Free-running clock and a cycle counter used for timing measurements.
   always #5 uart_clock = ~uart_clock;
   always @(posedge uart_clock) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: actual %0d, required %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Build the list of line levels for one frame from the configuration now on the inputs.
   task automatic buildFrame(input logic [DATA_W-1:0] w);
      int effDiv;
      int n;
      effDiv = (baud_div == 0) ? 1 : int'(baud_div);
      mBitLen = effDiv + 1;
      n = 0;
      mBits[n] = 0; n++;
      for (int i = 0; i < DATA_W; i++) begin
         mBits[n] = int'(w[i]); n++;
      end
      if (parity_mode == 2'b01 || parity_mode == 2'b10) begin
         mBits[n] = int'((^w) ^ (parity_mode == 2'b10)); n++;
      end
      mBits[n] = 1; n++;
      if (stop_bits) begin
         mBits[n] = 1; n++;
      end
      mNbits = n;
      mCycle = 0;
      mBusy  = 1'b1;
   endtask

   // Model: advance the frame in flight, start the next one from the queue, accept pushes.
   initial begin : modelProc
      int sizePre;
      bit pushOk;
      logic [DATA_W-1:0] w;
      forever begin
         @(posedge uart_clock or negedge uart_reset);
         if (!uart_reset) begin
            mQ.delete();
            mBusy  = 1'b0;
            mDone  = 1'b0;
            mCycle = 0;
         end else begin
            sizePre = mQ.size();
            pushOk  = tx_valid && (sizePre < FIFO_DEPTH);
            mDone   = 1'b0;
            if (mBusy) begin
               mCycle++;
               if (mCycle == mNbits * mBitLen) begin
                  mDone = 1'b1;
                  mBusy = 1'b0;
               end
            end
            if (!mBusy && sizePre > 0 && tx_enable) begin
               w = mQ.pop_front();
               buildFrame(w);
            end
            if (pushOk) begin
               mQ.push_back(tx_data);
            end
         end
      end
   end

   // Compare every output against the model on each falling edge outside reset.
   initial begin : compareProc
      int expLine;
      forever begin
         @(negedge uart_clock);
         if (uart_reset) begin
            expLine = mBusy ? mBits[mCycle / mBitLen] : 1;
            checkOutput("model uart_d_out", uart_d_out, expLine);
            checkOutput("model tx_busy", tx_busy, mBusy);
            checkOutput("model tx_done", tx_done, mDone);
            checkOutput("model fifo_level", fifo_level, mQ.size());
            checkOutput("model tx_ready", tx_ready, mQ.size() < FIFO_DEPTH);
         end
      end
   end

   // Drive one push for a single clock; called at a falling edge, returns at the next.
   task automatic applyStimulus(input logic valid, input logic [DATA_W-1:0] data);
      tx_valid = valid;
      tx_data  = data;
      @(negedge uart_clock);
      tx_valid = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge uart_clock);
   endtask

   task automatic waitDone(input string tag);
      int n = 0;
      while (!tx_done && n < 3000) begin
         @(negedge uart_clock);
         n++;
      end
      checkOutput({tag, " tx_done seen"}, tx_done, 1);
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while ((tx_busy || fifo_level != 0) && n < 8000) begin
         @(negedge uart_clock);
         n++;
      end
      checkOutput({tag, " idle reached"}, (!tx_busy && fifo_level == 0), 1);
   endtask

   // Push one word into an idle transmitter, sample one bit and measure the frame length.
   task automatic sendFrame(input logic [DATA_W-1:0] word, input int sampleAt, input int expBit,
                            input int expLen, input string tag);
      int c0;
      applyStimulus(1'b1, word);
      @(negedge uart_clock);
      c0 = cyc;
      checkOutput({tag, " start bit"}, uart_d_out, 0);
      waitCycles(sampleAt);
      checkOutput({tag, " sampled bit"}, uart_d_out, expBit);
      waitDone(tag);
      checkOutput({tag, " frame length"}, cyc - c0, expLen);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence.
   initial begin : stimProc
      int a5Bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
      int c0;
      int c1;
      int doneSeen;

      // Reset state
      repeat (3) @(negedge uart_clock);
      checkOutput("reset uart_d_out", uart_d_out, 1);
      checkOutput("reset tx_ready", tx_ready, 1);
      checkOutput("reset tx_busy", tx_busy, 0);
      checkOutput("reset tx_done", tx_done, 0);
      checkOutput("reset fifo_level", fifo_level, 0);
      uart_reset = 1'b1;
      @(negedge uart_clock);

      // 8N1, divisor 9, word 0xA5
      $display("[TB] 8N1 frame 0xA5");
      baud_div = 16'd9; parity_mode = 2'b00; stop_bits = 1'b0; tx_enable = 1'b1;
      applyStimulus(1'b1, 8'hA5);
      @(negedge uart_clock);
      c0 = cyc;
      for (int i = 0; i < 10; i++) begin
         waitCycles((i == 0) ? 5 : 10);
         checkOutput($sformatf("8N1 line bit %0d", i), uart_d_out, a5Bits[i]);
      end
      waitDone("8N1");
      checkOutput("8N1 tx_done offset", cyc - c0, 100);

      // Even and odd parity on 0x07 with 4-clock bits
      $display("[TB] parity frames");
      baud_div = 16'd3; parity_mode = 2'b01;
      sendFrame(8'h07, 38, 1, 44, "even parity");
      parity_mode = 2'b10;
      sendFrame(8'h07, 38, 0, 44, "odd parity");

      // FIFO fill with transmission disabled
      $display("[TB] FIFO full");
      tx_enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'h30 + 8'(i));
         if (i == 3) begin
            checkOutput("full tx_ready after 4", tx_ready, 0);
            checkOutput("full level after 4", fifo_level, 4);
         end
      end
      checkOutput("full level after 5th", fifo_level, 4);
      tx_enable = 1'b1;
      waitIdle("full drain");

      // Back-to-back frames, two stop bits, even parity, divisor 3
      $display("[TB] back-to-back frames");
      tx_enable = 1'b0; baud_div = 16'd3; stop_bits = 1'b1; parity_mode = 2'b01;
      applyStimulus(1'b1, 8'h3C);
      applyStimulus(1'b1, 8'hC3);
      tx_enable = 1'b1;
      waitDone("b2b first");
      c1 = cyc;
      checkOutput("b2b no idle gap", uart_d_out, 0);
      checkOutput("b2b still busy", tx_busy, 1);
      @(negedge uart_clock);
      waitDone("b2b second");
      checkOutput("b2b done spacing", cyc - c1, 48);

      // Divisor change in the middle of a frame
      $display("[TB] mid-frame divisor change");
      tx_enable = 1'b0; baud_div = 16'd9; stop_bits = 1'b0; parity_mode = 2'b00;
      applyStimulus(1'b1, 8'h55);
      applyStimulus(1'b1, 8'hF0);
      tx_enable = 1'b1;
      @(negedge uart_clock);
      c0 = cyc;
      waitCycles(20);
      baud_div = 16'd3;
      waitDone("divchg first");
      checkOutput("divchg first length", cyc - c0, 100);
      c1 = cyc;
      @(negedge uart_clock);
      waitDone("divchg second");
      checkOutput("divchg second length", cyc - c1, 40);

      // Reset during data bit 3, then a push right after release
      $display("[TB] reset mid-frame");
      baud_div = 16'd9;
      applyStimulus(1'b1, 8'h5A);
      applyStimulus(1'b1, 8'h66);
      waitCycles(45);
      #2 uart_reset = 1'b0;
      #1;
      checkOutput("abort uart_d_out", uart_d_out, 1);
      checkOutput("abort fifo_level", fifo_level, 0);
      checkOutput("abort tx_busy", tx_busy, 0);
      checkOutput("abort tx_ready", tx_ready, 1);
      checkOutput("abort tx_done", tx_done, 0);
      @(negedge uart_clock);
      @(negedge uart_clock);
      uart_reset = 1'b1;
      applyStimulus(1'b1, 8'h81);
      checkOutput("first push after reset", fifo_level, 1);
      doneSeen = 0;
      repeat (90) begin
         @(negedge uart_clock);
         if (tx_done) doneSeen++;
      end
      checkOutput("abort no tx_done", doneSeen, 0);
      waitDone("post-reset frame");

      // Randomized traffic with configuration and enable changes
      $display("[TB] randomized run");
      for (int i = 0; i < 2500; i++) begin
         if (i % 150 == 0) begin
            baud_div    = 16'($urandom_range(0, 4));
            parity_mode = 2'($urandom_range(0, 3));
            stop_bits   = 1'($urandom_range(0, 1));
         end
         if (i % 40 == 0) begin
            tx_enable = ($urandom_range(0, 4) != 0);
         end
         tx_valid = ($urandom_range(0, 3) == 0);
         tx_data  = 8'($urandom);
         if (i == 1300) begin
            #2 uart_reset = 1'b0;
            @(negedge uart_clock);
            uart_reset = 1'b1;
         end
         @(negedge uart_clock);
      end
      tx_valid  = 1'b0;
      tx_enable = 1'b1;
      waitIdle("random drain");
      waitCycles(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
